// File: rtl/float_pkg.sv
// Shared float helpers for the divider arbiter: field widths, zero test,
// signed special-value builders, FSM states and the in-flight tag entry.
package float_pkg;

    localparam int MAX_DW = 64;
    localparam int MAX_ID = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } arb_state_t;

    // One entry per operation in flight; sized for the widest supported format.
    typedef struct packed {
        logic              valid;
        logic [MAX_ID-1:0] id;
        logic              byp;
        logic [MAX_DW-1:0] byp_data;
        logic              dbz;
    } tag_t;

    function automatic int exp_bits(input int dw);
        case (dw)
            16:      return 5;
            64:      return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int man_bits(input int dw);
        return dw - 1 - exp_bits(dw);
    endfunction

    // Zero means exponent and mantissa both clear; the sign bit is ignored.
    function automatic logic is_zero(input logic [MAX_DW-1:0] x, input int dw);
        logic [MAX_DW-1:0] mask;
        mask = (MAX_DW'(1) << (dw - 1)) - MAX_DW'(1);
        return (x & mask) == '0;
    endfunction

    function automatic logic [MAX_DW-1:0] signed_inf(input logic sign, input int dw);
        logic [MAX_DW-1:0] expOnes;
        expOnes = ((MAX_DW'(1) << exp_bits(dw)) - MAX_DW'(1)) << man_bits(dw);
        return expOnes | (MAX_DW'(sign) << (dw - 1));
    endfunction

    function automatic logic [MAX_DW-1:0] signed_zero(input logic sign, input int dw);
        return MAX_DW'(sign) << (dw - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic         w_found;
    logic [W-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = W'((int'(ptr) + k) % N);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/float_div_arbiter.sv
// Shares one pipelined float divider between NUM_REQ requesters, tagging each
// issued operation so its result (or zero-operand bypass) returns to its owner.
module float_div_arbiter
    import float_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_REQ     = 4,
    parameter  int DIV_LATENCY = 5,
    localparam int ID_WIDTH    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          drain,
    output logic                          div_enb,
    output logic [DATA_WIDTH-1:0]         div_a,
    output logic [DATA_WIDTH-1:0]         div_b,
    input  logic [DATA_WIDTH-1:0]         div_c,
    output logic                          rsp_valid,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_dbz,
    output logic                          busy
);

    arb_state_t            r_state;
    arb_state_t            w_next_state;
    logic                  w_grant_en;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0]    w_gnt;
    logic [ID_WIDTH-1:0]   w_gnt_idx;
    logic                  w_any_grant;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic                  w_a_zero;
    logic                  w_b_zero;
    logic                  w_sign;
    logic [MAX_DW-1:0]     w_inf;
    logic [MAX_DW-1:0]     w_zero;
    tag_t                  w_new_tag;
    tag_t                  r_issue;
    tag_t                  r_tag [DIV_LATENCY];
    tag_t                  w_head;
    logic                  w_tag_any;
    logic                  r_div_enb;
    logic [DATA_WIDTH-1:0] r_div_a;
    logic [DATA_WIDTH-1:0] r_div_b;
    logic                  r_rsp_valid;
    logic [ID_WIDTH-1:0]   r_rsp_id;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_dbz;
    logic                  w_unused_head;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req     (req_valid),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (drain)  w_next_state = ST_DRAIN;
            ST_DRAIN: if (!drain) w_next_state = ST_RUN;
            default:  w_next_state = ST_RUN;
        endcase
    end

    // drain and rst both veto a grant in the very cycle they are seen.
    always_comb begin
        w_grant_en = (r_state == ST_RUN) && !drain && !rst;
    end

    assign req_ready   = w_grant_en ? w_gnt : '0;
    assign w_any_grant = |req_ready;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_a_zero = is_zero(MAX_DW'(w_sel_a), DATA_WIDTH);
    assign w_b_zero = is_zero(MAX_DW'(w_sel_b), DATA_WIDTH);
    assign w_sign   = w_sel_a[DATA_WIDTH-1] ^ w_sel_b[DATA_WIDTH-1];
    assign w_inf    = signed_inf(w_sign, DATA_WIDTH);
    assign w_zero   = signed_zero(w_sign, DATA_WIDTH);

    // A zero divisor wins over a zero dividend, so 0/0 yields a signed infinity.
    always_comb begin
        w_new_tag          = '0;
        w_new_tag.valid    = 1'b1;
        w_new_tag.id       = MAX_ID'(w_gnt_idx);
        w_new_tag.byp      = w_a_zero | w_b_zero;
        w_new_tag.dbz      = w_b_zero;
        w_new_tag.byp_data = w_b_zero ? w_inf : (w_a_zero ? w_zero : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_any_grant) begin
            r_rr_ptr <= (w_gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_WIDTH'(1);
        end
    end

    // Operands are zeroed when idle since the divider's hold logic keys off nonzero A.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_enb <= 1'b0;
            r_div_a   <= '0;
            r_div_b   <= '0;
            r_issue   <= '0;
        end else begin
            r_div_enb <= w_any_grant;
            r_div_a   <= w_any_grant ? w_sel_a : '0;
            r_div_b   <= w_any_grant ? w_sel_b : '0;
            r_issue   <= w_any_grant ? w_new_tag : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIV_LATENCY; i++) r_tag[i] <= '0;
        end else begin
            r_tag[0] <= r_issue;
            for (int i = 1; i < DIV_LATENCY; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    assign w_head = r_tag[DIV_LATENCY-1];

    always_comb begin
        w_tag_any = r_issue.valid;
        for (int i = 0; i < DIV_LATENCY; i++) w_tag_any = w_tag_any | r_tag[i].valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_rsp_dbz   <= 1'b0;
        end else begin
            r_rsp_valid <= w_head.valid;
            r_rsp_id    <= w_head.valid ? w_head.id[ID_WIDTH-1:0] : '0;
            r_rsp_data  <= !w_head.valid ? '0
                         : (w_head.byp ? w_head.byp_data[DATA_WIDTH-1:0] : div_c);
            r_rsp_dbz   <= w_head.valid & w_head.dbz;
        end
    end

    assign w_unused_head = ^{w_head.byp_data, w_head.id};

    assign div_enb   = r_div_enb;
    assign div_a     = r_div_a;
    assign div_b     = r_div_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign rsp_dbz   = r_rsp_dbz;
    assign busy      = w_any_grant | r_div_enb | w_tag_any | r_rsp_valid;

endmodule
